// File: rtl/calc1_req_driver.sv
// Per-port request sequencer for one calc1 requester port: buffers whole operations,
// serialises them into the two-cycle calc1 request protocol and returns tagged results.
module calc1_req_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:3]       in_cmd,
  input  logic [0:31]      in_op1,
  input  logic [0:31]      in_op2,
  input  logic [0:TAG_W-1] in_tag,
  output logic [0:3]       req_cmd_out,
  output logic [0:31]      req_data_out,
  input  logic [0:1]       calc_resp,
  input  logic [0:31]      calc_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [0:1]       rsp_resp,
  output logic [0:31]      rsp_data,
  output logic [0:TAG_W-1] rsp_tag,
  output logic             rsp_timeout,
  output logic             busy,
  output logic             err_unexpected
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE1, S_ISSUE2, S_WAIT, S_RESP} state_t;

  logic [0:3]       mem_cmd [FIFO_DEPTH];
  logic [0:31]      mem_op1 [FIFO_DEPTH];
  logic [0:31]      mem_op2 [FIFO_DEPTH];
  logic [0:TAG_W-1] mem_tag [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:31]      op2_q, op2_d;
  logic [0:TAG_W-1] tag_q, tag_d;
  logic [0:3]       req_cmd_q, req_cmd_d;
  logic [0:31]      req_data_q, req_data_d;
  logic [0:1]       rsp_resp_q, rsp_resp_d;
  logic [0:31]      rsp_data_q, rsp_data_d;
  logic [0:TAG_W-1] rsp_tag_q, rsp_tag_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             err_q, err_d;
  logic             full, push, pop;

  // Both interfaces use valid/ready: a transfer happens on a rising edge where valid
  // and ready are both high; valid and its payload stay stable until that edge.
  assign full = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
  assign push = in_valid && !full;
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  always_ff @(posedge c_clk) begin
    if (push) begin
      mem_cmd[wr_ptr_q] <= in_cmd;
      mem_op1[wr_ptr_q] <= in_op1;
      mem_op2[wr_ptr_q] <= in_op2;
      mem_tag[wr_ptr_q] <= in_tag;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op2_d         = op2_q;
    tag_d         = tag_q;
    req_cmd_d     = req_cmd_q;
    req_data_d    = req_data_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_data_d    = rsp_data_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_timeout_d = rsp_timeout_q;
    err_d         = err_q | ((calc_resp != 2'b00) && (state_q != S_WAIT));
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          op2_d = mem_op2[rd_ptr_q];
          tag_d = mem_tag[rd_ptr_q];
          if (mem_cmd[rd_ptr_q] != 4'd0) begin
            req_cmd_d  = mem_cmd[rd_ptr_q];
            req_data_d = mem_op1[rd_ptr_q];
            state_d    = S_ISSUE1;
          end else begin
            // A no-op command is answered locally and never reaches calc1.
            rsp_resp_d    = 2'b00;
            rsp_data_d    = '0;
            rsp_tag_d     = mem_tag[rd_ptr_q];
            rsp_timeout_d = 1'b0;
            state_d       = S_RESP;
          end
        end
      end
      S_ISSUE1: begin
        req_cmd_d  = 4'd0;
        req_data_d = op2_q;
        state_d    = S_ISSUE2;
      end
      S_ISSUE2: begin
        req_cmd_d  = 4'd0;
        req_data_d = '0;
        cnt_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (calc_resp != 2'b00) begin
          rsp_resp_d    = calc_resp;
          rsp_data_d    = calc_data;
          rsp_tag_d     = tag_q;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_resp_d    = 2'b00;
          rsp_data_d    = '0;
          rsp_tag_d     = tag_q;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op2_q         <= '0;
      tag_q         <= '0;
      req_cmd_q     <= '0;
      req_data_q    <= '0;
      rsp_resp_q    <= '0;
      rsp_data_q    <= '0;
      rsp_tag_q     <= '0;
      rsp_timeout_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op2_q         <= op2_d;
      tag_q         <= tag_d;
      req_cmd_q     <= req_cmd_d;
      req_data_q    <= req_data_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_data_q    <= rsp_data_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_timeout_q <= rsp_timeout_d;
      err_q         <= err_d;
    end
  end

  assign in_ready       = !full;
  assign req_cmd_out    = req_cmd_q;
  assign req_data_out   = req_data_q;
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_resp       = rsp_resp_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_tag        = rsp_tag_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign busy           = (state_q != S_IDLE) || (count_q != '0);
  assign err_unexpected = err_q;
endmodule

// File: tb/tb_calc1_req_driver.sv
// Directed bench for calc1_req_driver: the bench plays the calc1 port by hand and
// checks issue timing, responses, timeout, ordering, backpressure and reset.
module tb_calc1_req_driver;
  localparam int TAG_W = 4;

  logic             c_clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [0:3]       in_cmd = '0;
  logic [0:31]      in_op1 = '0;
  logic [0:31]      in_op2 = '0;
  logic [0:TAG_W-1] in_tag = '0;
  logic [0:3]       req_cmd_out;
  logic [0:31]      req_data_out;
  logic [0:1]       calc_resp = '0;
  logic [0:31]      calc_data = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [0:1]       rsp_resp;
  logic [0:31]      rsp_data;
  logic [0:TAG_W-1] rsp_tag;
  logic             rsp_timeout;
  logic             busy;
  logic             err_unexpected;

  int total = 0;
  int bad = 0;
  logic [TAG_W-1:0] exp_q[$];

  calc1_req_driver #(.FIFO_DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(64)) dut (
    .c_clk(c_clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_op1(in_op1),
    .in_op2(in_op2), .in_tag(in_tag),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .calc_resp(calc_resp), .calc_data(calc_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
    .busy(busy), .err_unexpected(err_unexpected)
  );

  always #5 c_clk = ~c_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic push_op(input logic [3:0] cmd, input logic [31:0] op1,
                         input logic [31:0] op2, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1; in_cmd = cmd; in_op1 = op1; in_op2 = op2; in_tag = tag;
    @(negedge c_clk);
    in_valid = 1'b0;
  endtask

  // Waits for an issue, then answers in the first WAIT cycle; returns in the RESP cycle.
  task automatic serve_op(input logic [1:0] resp, input logic [31:0] data);
    int n = 0;
    while (req_cmd_out == 4'd0 && n < 300) begin
      @(negedge c_clk); n++;
    end
    total++;
    if (req_cmd_out == 4'd0) begin
      bad++;
      $display("FAIL serve_issue: got no issue within %0d cycles, required one", n);
    end else begin
      @(negedge c_clk);
      @(negedge c_clk);
      calc_resp = resp; calc_data = data;
      @(negedge c_clk);
      calc_resp = '0; calc_data = '0;
    end
  endtask

  task automatic ack_rsp();
    int n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge c_clk); n++;
    end
    rsp_ready = 1'b1;
    @(negedge c_clk);
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge c_clk);
    total++;
    if ({in_ready, rsp_valid, busy, err_unexpected} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_flags: got %b required 1000", {in_ready, rsp_valid, busy, err_unexpected});
    end
    total++;
    if ({req_cmd_out, req_data_out} !== 36'h0) begin
      bad++;
      $display("FAIL reset_req: got %h required 0", {req_cmd_out, req_data_out});
    end
    total++;
    if ({rsp_resp, rsp_data, rsp_tag, rsp_timeout} !== 39'h0) begin
      bad++;
      $display("FAIL reset_rsp: got %h required 0", {rsp_resp, rsp_data, rsp_tag, rsp_timeout});
    end
    reset = 1'b1;
    @(negedge c_clk);
  endtask

  task automatic test_add();
    push_op(4'd1, 32'h5, 32'h3, 4'hA);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL add_busy: got %b required 1", busy); end
    @(negedge c_clk);
    total++;
    if ({req_cmd_out, req_data_out} !== {4'd1, 32'h5}) begin
      bad++; $display("FAIL add_issue1: got %h required %h", {req_cmd_out, req_data_out}, {4'd1, 32'h5});
    end
    @(negedge c_clk);
    total++;
    if ({req_cmd_out, req_data_out} !== {4'd0, 32'h3}) begin
      bad++; $display("FAIL add_issue2: got %h required %h", {req_cmd_out, req_data_out}, {4'd0, 32'h3});
    end
    @(negedge c_clk);
    total++;
    if ({req_cmd_out, req_data_out} !== 36'h0) begin
      bad++; $display("FAIL add_wait_idle_bus: got %h required 0", {req_cmd_out, req_data_out});
    end
    @(negedge c_clk);
    @(negedge c_clk);
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid: got %b required 0", rsp_valid); end
    calc_resp = 2'b01; calc_data = 32'h8;
    @(negedge c_clk);
    calc_resp = '0; calc_data = '0;
    total++;
    if ({rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_timeout} !== {1'b1, 2'b01, 32'h8, 4'hA, 1'b0}) begin
      bad++;
      $display("FAIL add_rsp: got v=%b r=%b d=%h t=%h to=%b required v=1 r=01 d=00000008 t=a to=0",
               rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_timeout);
    end
    ack_rsp();
    total++;
    if ({rsp_valid, busy, err_unexpected} !== 3'b000) begin
      bad++; $display("FAIL add_after_ack: got %b required 000", {rsp_valid, busy, err_unexpected});
    end
  endtask

  task automatic test_cmd0_stray();
    push_op(4'd0, 32'h1234, 32'h5678, 4'd3);
    total++;
    if (req_cmd_out !== 4'd0) begin bad++; $display("FAIL cmd0_req_a: got %h required 0", req_cmd_out); end
    @(negedge c_clk);
    total++;
    if ({rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_timeout, req_cmd_out} !==
        {1'b1, 2'b00, 32'h0, 4'd3, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL cmd0_rsp: got v=%b r=%b d=%h t=%h to=%b cmd=%h required v=1 r=00 d=0 t=3 to=0 cmd=0",
               rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_timeout, req_cmd_out);
    end
    ack_rsp();
    total++;
    if ({req_cmd_out, err_unexpected} !== 5'b0) begin
      bad++; $display("FAIL cmd0_req_b: got %b required 0", {req_cmd_out, err_unexpected});
    end
    calc_resp = 2'b01;
    @(negedge c_clk);
    calc_resp = '0;
    total++;
    if (err_unexpected !== 1'b1) begin bad++; $display("FAIL stray_err_set: got %b required 1", err_unexpected); end
    repeat (3) @(negedge c_clk);
    total++;
    if (err_unexpected !== 1'b1) begin bad++; $display("FAIL stray_err_sticky: got %b required 1", err_unexpected); end
  endtask

  task automatic test_overflow();
    push_op(4'd1, 32'hFFFF_FFFF, 32'h1, 4'd5);
    serve_op(2'b10, 32'h0);
    total++;
    if ({rsp_valid, rsp_resp, rsp_tag, rsp_timeout} !== {1'b1, 2'b10, 4'd5, 1'b0}) begin
      bad++; $display("FAIL ovf_rsp: got v=%b r=%b t=%h to=%b required v=1 r=10 t=5 to=0",
                      rsp_valid, rsp_resp, rsp_tag, rsp_timeout);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge c_clk);
      total++;
      if ({rsp_valid, rsp_resp, rsp_tag} !== {1'b1, 2'b10, 4'd5}) begin
        bad++; $display("FAIL ovf_hold%0d: got v=%b r=%b t=%h required v=1 r=10 t=5", i, rsp_valid, rsp_resp, rsp_tag);
      end
    end
    rsp_ready = 1'b1;
    @(negedge c_clk);
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL ovf_release: got %b required 0", rsp_valid); end
  endtask

  task automatic test_timeout();
    push_op(4'd5, 32'h11, 32'h22, 4'd7);
    push_op(4'd1, 32'h33, 32'h44, 4'd8);
    total++;
    if ({req_cmd_out, req_data_out} !== {4'd5, 32'h11}) begin
      bad++; $display("FAIL to_issue: got %h required %h", {req_cmd_out, req_data_out}, {4'd5, 32'h11});
    end
    repeat (65) @(negedge c_clk);
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL to_early: got %b required 0 after 63 WAIT cycles", rsp_valid); end
    @(negedge c_clk);
    total++;
    if ({rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_timeout} !== {1'b1, 2'b00, 32'h0, 4'd7, 1'b1}) begin
      bad++; $display("FAIL to_rsp: got v=%b r=%b d=%h t=%h to=%b required v=1 r=00 d=0 t=7 to=1",
                      rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_timeout);
    end
    rsp_ready = 1'b1;
    @(negedge c_clk);
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL to_release: got %b required 0", rsp_valid); end
    @(negedge c_clk);
    total++;
    if ({req_cmd_out, req_data_out} !== {4'd1, 32'h33}) begin
      bad++; $display("FAIL to_next_issue: got %h required %h", {req_cmd_out, req_data_out}, {4'd1, 32'h33});
    end
    serve_op(2'b01, 32'h77);
    total++;
    if ({rsp_valid, rsp_data, rsp_tag, rsp_timeout} !== {1'b1, 32'h77, 4'd8, 1'b0}) begin
      bad++; $display("FAIL to_next_rsp: got v=%b d=%h t=%h to=%b required v=1 d=77 t=8 to=0",
                      rsp_valid, rsp_data, rsp_tag, rsp_timeout);
    end
    ack_rsp();
  endtask

  task automatic test_back_to_back();
    logic [5:0] acc;
    logic [TAG_W-1:0] exp;
    logic pushed6;
    int n;
    acc = '0;
    rsp_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_cmd = 4'd2; in_op1 = 32'(i); in_op2 = 32'h1; in_tag = TAG_W'(i);
      acc[i-1] = in_ready;
      @(negedge c_clk);
    end
    in_valid = 1'b0;
    total++;
    if (acc !== 6'b011111) begin bad++; $display("FAIL b2b_accept: got %b required 011111", acc); end
    total++;
    if ({in_ready, busy} !== 2'b01) begin bad++; $display("FAIL b2b_full: got %b required 01", {in_ready, busy}); end
    for (int i = 1; i <= 6; i++) exp_q.push_back(TAG_W'(i));
    rsp_ready = 1'b1;
    pushed6 = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      if (rsp_valid) begin
        exp = exp_q.pop_front();
        total++;
        if ({rsp_tag, rsp_timeout} !== {exp, 1'b1}) begin
          bad++; $display("FAIL b2b_order: got tag=%h to=%b required tag=%h to=1", rsp_tag, rsp_timeout, exp);
        end
      end
      if (in_valid) in_valid = 1'b0;
      else if (!pushed6 && in_ready) begin
        in_valid = 1'b1; in_cmd = 4'd2; in_op1 = 32'h6; in_op2 = 32'h1; in_tag = TAG_W'(6);
        pushed6 = 1'b1;
      end
      @(negedge c_clk);
      n++;
    end
    rsp_ready = 1'b0;
    in_valid = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_drain: got %0d responses missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_wait();
    logic seen;
    push_op(4'd1, 32'h1, 32'h2, 4'd9);
    push_op(4'd1, 32'h3, 32'h4, 4'd10);
    push_op(4'd1, 32'h5, 32'h6, 4'd11);
    @(negedge c_clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy: got %b required 1", busy); end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({in_ready, busy, rsp_valid, err_unexpected} !== 4'b1000) begin
      bad++; $display("FAIL rst_async_flags: got %b required 1000", {in_ready, busy, rsp_valid, err_unexpected});
    end
    total++;
    if ({req_cmd_out, req_data_out, rsp_resp, rsp_data, rsp_tag, rsp_timeout} !== 75'h0) begin
      bad++; $display("FAIL rst_async_outs: got %h required 0",
                      {req_cmd_out, req_data_out, rsp_resp, rsp_data, rsp_tag, rsp_timeout});
    end
    @(negedge c_clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge c_clk);
      if (rsp_valid || busy || req_cmd_out != 4'd0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rst_quiet: got activity=%b required 0", seen); end
    push_op(4'd3, 32'h10, 32'h20, 4'd12);
    serve_op(2'b01, 32'h200);
    total++;
    if ({rsp_valid, rsp_data, rsp_tag} !== {1'b1, 32'h200, 4'd12}) begin
      bad++; $display("FAIL rst_new_op: got v=%b d=%h t=%h required v=1 d=200 t=c", rsp_valid, rsp_data, rsp_tag);
    end
    ack_rsp();
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmd0_stray();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
